wb_arbiter: RTL and testbench

- Writeback collection stage directly downstream of the execute stage.
- Captures the independent result streams the execute stage produces: fixed-latency unit, load, store and FPU.
- Buffers each stream in a small per-source FIFO.
- Each cycle, forwards up to NR_WB_PORTS results to the scoreboard write ports under round-robin arbitration, with per-source backpressure to issue.

---
 rtl/wb_arbiter_pkg.sv | 26 ++
 rtl/wb_src_fifo.sv | 60 ++++++
 rtl/wb_arbiter.sv | 112 +++++++++++
 tb/tb_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback collection stage.
// Defines the per-source result entry and the fixed source numbering.
// Imported by the source FIFO and the arbiter top.
package wb_arbiter_pkg;

    localparam int TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t               ex;
    } wb_entry_t;

    localparam int NR_WB_SRC = 4;
    localparam int SRC_FLU   = 0;
    localparam int SRC_LOAD  = 1;
    localparam int SRC_STORE = 2;
    localparam int SRC_FPU   = 3;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result buffer between an execute unit and the writeback arbiter.
// Latency: an entry pushed at edge N is at the head from cycle N+1; no bypass.
// Backpressure: full reflects registered count only; a push into a full FIFO that is not popped is dropped and pulses overflow.
module wb_src_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t data_in,
    output wb_entry_t data_out,
    output logic      full,
    output logic      empty,
    output logic      overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // A full FIFO still takes a new entry when its head leaves in the same cycle.
    assign push_ok  = push && !flush_i && (!full || pop);
    assign overflow = push && !flush_i && full && !pop;
    assign data_out = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the FIFO like reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed while the slot is occupied.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Collects FLU/load/store/FPU results and forwards up to NR_WB_PORTS per cycle to the scoreboard, round-robin.
// Latency: one cycle from result valid to writeback port; heads are muxed combinationally.
// Backpressure: src_ready low while that source FIFO is full; no backpressure from the write ports.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NR_SRC      = NR_WB_SRC,
    parameter int NR_WB_PORTS = 2,
    parameter int DEPTH       = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       flush_i,
    input  logic       [NR_SRC-1:0]                    src_valid_i,
    input  logic       [NR_SRC-1:0][63:0]              src_result_i,
    input  logic       [NR_SRC-1:0][TRANS_ID_BITS-1:0] src_trans_id_i,
    input  exception_t [NR_SRC-1:0]                    src_ex_i,
    output logic       [NR_SRC-1:0]                    src_ready_o,
    output logic       [NR_WB_PORTS-1:0]               wt_valid_o,
    output logic       [NR_WB_PORTS-1:0][63:0]         wbdata_o,
    output logic       [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_o,
    output exception_t [NR_WB_PORTS-1:0]               ex_o,
    output logic                                       overflow_o
);

    localparam int SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

    wb_entry_t              head [NR_SRC];
    logic [NR_SRC-1:0]      full;
    logic [NR_SRC-1:0]      empty;
    logic [NR_SRC-1:0]      ovf;
    logic [NR_SRC-1:0]      pop;
    logic [NR_SRC-1:0]      req;
    logic [NR_WB_PORTS-1:0] gnt_vld;
    logic [SRC_W-1:0]       gnt_src [NR_WB_PORTS];
    logic [SRC_W-1:0]       rr_q;
    logic [SRC_W-1:0]       rr_d;

    for (genvar g = 0; g < NR_SRC; g++) begin : gen_src
        wb_entry_t entry;
        assign entry = '{result: src_result_i[g], trans_id: src_trans_id_i[g], ex: src_ex_i[g]};

        wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .flush_i  (flush_i),
            .push     (src_valid_i[g]),
            .pop      (pop[g]),
            .data_in  (entry),
            .data_out (head[g]),
            .full     (full[g]),
            .empty    (empty[g]),
            .overflow (ovf[g])
        );
    end

    assign src_ready_o = ~full;
    // A flush cycle grants nothing, so nothing is written back and rr_q holds.
    assign req = ~empty & {NR_SRC{~flush_i}};

    // Port k takes the k-th requesting source in scan order starting at rr_q; a source is granted at most once.
    always_comb begin
        logic [NR_SRC-1:0] taken;
        logic [SRC_W-1:0]  idx;
        taken = '0;
        idx   = '0;
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            gnt_vld[k] = 1'b0;
            gnt_src[k] = '0;
            for (int s = 0; s < NR_SRC; s++) begin
                idx = SRC_W'((int'(rr_q) + s) % NR_SRC);
                if (!gnt_vld[k] && req[idx] && !taken[idx]) begin
                    gnt_vld[k] = 1'b1;
                    gnt_src[k] = idx;
                end
            end
            if (gnt_vld[k]) taken[gnt_src[k]] = 1'b1;
        end
    end

    // Output mux, head dequeue and next round-robin pointer (one past the last grant).
    always_comb begin
        pop        = '0;
        rr_d       = rr_q;
        wt_valid_o = '0;
        wbdata_o   = '0;
        trans_id_o = '0;
        ex_o       = '0;
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            if (gnt_vld[k]) begin
                pop[gnt_src[k]] = 1'b1;
                wt_valid_o[k]   = 1'b1;
                wbdata_o[k]     = head[gnt_src[k]].result;
                trans_id_o[k]   = head[gnt_src[k]].trans_id;
                ex_o[k]         = head[gnt_src[k]].ex;
                rr_d            = SRC_W'((int'(gnt_src[k]) + 1) % NR_SRC);
            end
        end
    end

    // Round-robin pointer and sticky overflow flag; only reset clears the flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (|gnt_vld) rr_q <= rr_d;
            if (|ovf)     overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a two-port instance (a) and a one-port instance (b).
// Stimulus pushes hand-computed writebacks (cycle, port, id, data) into per-instance queues.
// A negedge monitor pops and compares every valid writeback and checks idle ports drive zero.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    typedef struct {
        int                       cyc;
        int                       port;
        logic [TRANS_ID_BITS-1:0] id;
        logic [63:0]              data;
        logic                     exv;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush_a, flush_b;
    logic       [3:0]                    va, vb, rdy_a, rdy_b;
    logic       [3:0][63:0]              res_a, res_b;
    logic       [3:0][TRANS_ID_BITS-1:0] id_a, id_b;
    exception_t [3:0]                    exi_a, exi_b;
    logic       [1:0]                    wv_a;
    logic       [1:0][63:0]              wd_a;
    logic       [1:0][TRANS_ID_BITS-1:0] wi_a;
    exception_t [1:0]                    wx_a;
    logic       [0:0]                    wv_b;
    logic       [0:0][63:0]              wd_b;
    logic       [0:0][TRANS_ID_BITS-1:0] wi_b;
    exception_t [0:0]                    wx_b;
    logic ovf_a, ovf_b;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   started = 1'b0;

    wb_arbiter #(.NR_SRC(4), .NR_WB_PORTS(2), .DEPTH(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .src_valid_i(va), .src_result_i(res_a),
        .src_trans_id_i(id_a), .src_ex_i(exi_a), .src_ready_o(rdy_a), .wt_valid_o(wv_a),
        .wbdata_o(wd_a), .trans_id_o(wi_a), .ex_o(wx_a), .overflow_o(ovf_a)
    );

    wb_arbiter #(.NR_SRC(4), .NR_WB_PORTS(1), .DEPTH(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .src_valid_i(vb), .src_result_i(res_b),
        .src_trans_id_i(id_b), .src_ex_i(exi_b), .src_ready_o(rdy_b), .wt_valid_o(wv_b),
        .wbdata_o(wd_b), .trans_id_o(wi_b), .ex_o(wx_b), .overflow_o(ovf_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input int inst, input int p, input logic v, input logic [TRANS_ID_BITS-1:0] id,
                       input logic [63:0] d, input exception_t ex);
        exp_t e;
        checks++;
        if (!v) begin
            if (id !== '0 || d !== '0 || ex !== '0) begin
                errors++;
                $display("FAIL idle_port_zero inst %0d port %0d cycle %0d: got id %0d data %h exv %b, expected all zero",
                         inst, p, cyc, id, d, ex.valid);
            end
        end else if ((inst == 0 && qa.size() == 0) || (inst == 1 && qb.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_wb inst %0d port %0d cycle %0d: got id %0d data %h, expected no writeback",
                     inst, p, cyc, id, d);
        end else begin
            if (inst == 0) e = qa.pop_front();
            else           e = qb.pop_front();
            if (e.cyc != cyc || e.port != p || e.id !== id || e.data !== d || e.exv !== ex.valid) begin
                errors++;
                $display("FAIL wb_match inst %0d: got cycle %0d port %0d id %0d data %h exv %b, expected cycle %0d port %0d id %0d data %h exv %b",
                         inst, cyc, p, id, d, ex.valid, e.cyc, e.port, e.id, e.data, e.exv);
            end
        end
    endtask

    // Monitor: every cycle, every port of both instances.
    always @(negedge clk) begin
        if (started) begin
            for (int p = 0; p < 2; p++) mon(0, p, wv_a[p], wi_a[p], wd_a[p], wx_a[p]);
            mon(1, 0, wv_b[0], wi_b[0], wd_b[0], wx_b[0]);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        va = '0; vb = '0; flush_a = 1'b0; flush_b = 1'b0;
    endtask

    task automatic put_a(input logic [1:0] s, input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] d, input logic exv);
        va[s] = 1'b1; id_a[s] = id; res_a[s] = d;
        exi_a[s] = '0; exi_a[s].valid = exv; exi_a[s].cause = exv ? 64'hD : 64'h0;
    endtask

    task automatic put_b(input logic [1:0] s, input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] d, input logic exv);
        vb[s] = 1'b1; id_b[s] = id; res_b[s] = d;
        exi_b[s] = '0; exi_b[s].valid = exv; exi_b[s].cause = exv ? 64'hD : 64'h0;
    endtask

    task automatic exp_a(input int c, input int p, input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] d, input logic exv);
        qa.push_back('{c, p, id, d, exv});
    endtask

    task automatic exp_b(input int c, input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] d);
        qb.push_back('{c, 0, id, d, 1'b0});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, n0, n3;
        rst = 1'b1; idle();
        res_a = '0; id_a = '0; exi_a = '0; res_b = '0; id_b = '0; exi_b = '0;
        step(); step();
        started = 1'b1;
        chk("reset_ready_a", 64'(rdy_a), 64'hF);
        chk("reset_ready_b", 64'(rdy_b), 64'hF);
        chk("reset_valid_a", 64'(wv_a), 64'h0);
        chk("reset_valid_b", 64'(wv_b), 64'h0);
        chk("reset_overflow", 64'({ovf_a, ovf_b}), 64'h0);
        rst = 1'b0;

        // Contention on the two-port instance, rr_q = 0; source 3 carries an exception.
        c = cyc;
        for (int s = 0; s < 4; s++) put_a(2'(s), 3'(s), 64'h100 + 64'(s), (s == 3));
        exp_a(c + 1, 0, 0, 64'h100, 1'b0);
        exp_a(c + 1, 1, 1, 64'h101, 1'b0);
        exp_a(c + 2, 0, 2, 64'h102, 1'b0);
        exp_a(c + 2, 1, 3, 64'h103, 1'b1);
        step(); idle(); step(); step(); step();
        chk("contention_drained", 64'(qa.size()), 64'h0);

        // Single result from the load source.
        c = cyc;
        put_a(2'd1, 3'd5, 64'hDEAD, 1'b0);
        exp_a(c + 1, 0, 5, 64'hDEAD, 1'b0);
        step(); idle();
        chk("single_valid_c1", 64'(wv_a), 64'h1);
        step();
        chk("single_valid_c2", 64'(wv_a), 64'h0);
        step();
        chk("single_drained", 64'(qa.size()), 64'h0);

        // Flush with three buffered entries and a same-cycle push; rr_q (=2) must hold.
        put_a(2'd0, 3'd1, 64'h200, 1'b0);
        put_a(2'd1, 3'd2, 64'h201, 1'b0);
        put_a(2'd2, 3'd3, 64'h202, 1'b0);
        step(); idle();
        flush_a = 1'b1;
        put_a(2'd0, 3'd4, 64'h203, 1'b0);
        #1;
        chk("flush_cycle_valid", 64'(wv_a), 64'h0);
        step(); idle();
        chk("flush_next_valid", 64'(wv_a), 64'h0);
        chk("flush_ready", 64'(rdy_a), 64'hF);
        chk("flush_overflow", 64'(ovf_a), 64'h0);
        put_a(2'd0, 3'd5, 64'h300, 1'b0);
        put_a(2'd2, 3'd6, 64'h302, 1'b0);
        exp_a(cyc + 1, 0, 6, 64'h302, 1'b0);
        exp_a(cyc + 1, 1, 5, 64'h300, 1'b0);
        step(); idle(); step(); step();
        chk("flush_drained", 64'(qa.size()), 64'h0);

        // Fairness on the one-port instance: FLU and FPU sources issue whenever ready.
        c = cyc;
        for (int j = 0; j < 8; j++) begin
            if (j % 2 == 0) exp_b(c + 1 + j, 3'(j / 2), 64'hA000 + 64'(j / 2));
            else            exp_b(c + 1 + j, 3'(4 + j / 2), 64'hB000 + 64'(j / 2));
        end
        n0 = 0; n3 = 0;
        for (int k = 0; k < 6; k++) begin
            vb = '0;
            if (rdy_b[0]) begin put_b(2'd0, 3'(n0), 64'hA000 + 64'(n0), 1'b0); n0++; end
            if (rdy_b[3]) begin put_b(2'd3, 3'(4 + n3), 64'hB000 + 64'(n3), 1'b0); n3++; end
            step();
        end
        idle(); repeat (4) step();
        chk("fair_drained", 64'(qb.size()), 64'h0);
        chk("fair_pushes", 64'(n0 + n3), 64'd8);
        chk("fair_no_overflow", 64'(ovf_b), 64'h0);

        // Overflow: store source pushes four cycles while FLU and load hold the single port.
        c = cyc;
        put_b(2'd0, 3'd0, 64'hC000, 1'b0);
        put_b(2'd1, 3'd1, 64'hC001, 1'b0);
        put_b(2'd2, 3'd2, 64'hC200, 1'b0);
        exp_b(c + 1, 0, 64'hC000);
        exp_b(c + 2, 1, 64'hC001);
        exp_b(c + 3, 2, 64'hC200);
        exp_b(c + 4, 3, 64'hC201);
        exp_b(c + 5, 5, 64'hC203);
        step(); vb = '0; put_b(2'd2, 3'd3, 64'hC201, 1'b0);
        step(); vb = '0;
        chk("ovf_ready_drop", 64'(rdy_b[2]), 64'h0);
        chk("ovf_not_yet", 64'(ovf_b), 64'h0);
        put_b(2'd2, 3'd4, 64'hC202, 1'b0);
        step(); vb = '0;
        chk("ovf_set", 64'(ovf_b), 64'h1);
        put_b(2'd2, 3'd5, 64'hC203, 1'b0);
        step(); idle(); repeat (3) step();
        chk("ovf_sticky", 64'(ovf_b), 64'h1);
        chk("ovf_drained", 64'(qb.size()), 64'h0);
        flush_b = 1'b1;
        step(); idle();
        chk("ovf_hold_flush", 64'(ovf_b), 64'h1);

        // Reset mid-operation with buffered entries and overflow set; rr_q is 3 here.
        c = cyc;
        for (int s = 0; s < 4; s++) put_b(2'(s), 3'(s), 64'hE000 + 64'(s), 1'b0);
        exp_b(c + 1, 3, 64'hE003);
        exp_b(c + 2, 0, 64'hE000);
        step();
        for (int s = 0; s < 4; s++) put_b(2'(s), 3'(4 + s), 64'hE100 + 64'(s), 1'b0);
        step(); idle(); rst = 1'b1;
        step(); rst = 1'b0;
        chk("rst_valid", 64'(wv_b), 64'h0);
        chk("rst_overflow", 64'(ovf_b), 64'h0);
        chk("rst_ready", 64'(rdy_b), 64'hF);
        chk("rst_queue", 64'(qb.size()), 64'h0);
        put_b(2'd3, 3'd6, 64'hF003, 1'b0);
        exp_b(cyc + 1, 6, 64'hF003);
        step(); idle();
        chk("rst_fresh_valid", 64'(wv_b), 64'h1);
        step(); step();
        chk("rst_drained", 64'(qb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
